// File: rtl/carry_lookahead_adder.sv
// Two-level carry-lookahead adder: per-group lookahead feeding a lookahead unit
// across groups, with the sum and carry-out registered for a one-cycle latency.
module carry_lookahead_adder #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NG = WIDTH / SIZE;

  generate
    if (WIDTH < 1 || SIZE < 1 || (WIDTH % SIZE) != 0) begin : g_bad_params
      $error("carry_lookahead_adder: WIDTH must be >= 1 and a multiple of SIZE >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      cg;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  // Bit generate/propagate and the group-level GG/GP in sum-of-products form.
  always_comb begin : grp_pg
    logic term;
    logic gg_acc;
    logic gp_acc;
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    for (int k = 0; k < NG; k++) begin
      gg_acc = 1'b0;
      gp_acc = 1'b1;
      for (int m = 0; m < SIZE; m++) begin
        term = g[k*SIZE+m];
        for (int n = m + 1; n < SIZE; n++) begin
          term = term & p[k*SIZE+n];
        end
        gg_acc = gg_acc | term;
        gp_acc = gp_acc & p[k*SIZE+m];
      end
      gg[k] = gg_acc;
      gp[k] = gp_acc;
    end
  end

  // Second level: every group carry-in is built directly from GG/GP and cin.
  always_comb begin : grp_carry
    logic term;
    logic acc;
    cg    = '0;
    cg[0] = cin;
    for (int k = 0; k < NG; k++) begin
      acc = 1'b0;
      for (int m = 0; m <= k; m++) begin
        term = gg[m];
        for (int n = m + 1; n <= k; n++) begin
          term = term & gp[n];
        end
        acc = acc | term;
      end
      term = cin;
      for (int n = 0; n <= k; n++) begin
        term = term & gp[n];
      end
      cg[k+1] = acc | term;
    end
  end

  // Intra-group carries expanded from the group carry-in; no ripple chain.
  always_comb begin : bit_carry
    logic term;
    logic acc;
    c = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < SIZE; j++) begin
        acc = 1'b0;
        for (int m = 0; m < j; m++) begin
          term = g[k*SIZE+m];
          for (int n = m + 1; n < j; n++) begin
            term = term & p[k*SIZE+n];
          end
          acc = acc | term;
        end
        term = cg[k];
        for (int n = 0; n < j; n++) begin
          term = term & p[k*SIZE+n];
        end
        c[k*SIZE+j] = acc | term;
      end
    end
    s_d    = p ^ c;
    cout_d = cg[NG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Scoreboard bench for carry_lookahead_adder across four WIDTH/SIZE configurations
// sharing one stimulus stream (narrower instances see the low operand bits).
module tb_carry_lookahead_adder;

  logic        clk;
  logic        rst;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        cin_r;

  logic [15:0] s16_4;
  logic        co16_4;
  logic [15:0] s16_16;
  logic        co16_16;
  logic [7:0]  s8_1;
  logic        co8_1;
  logic [31:0] s32_8;
  logic        co32_8;

  typedef struct {
    logic [16:0] e16;
    logic [8:0]  e8;
    logic [32:0] e32;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  carry_lookahead_adder #(.WIDTH(16), .SIZE(4)) u_16_4 (
    .clk(clk), .rst(rst), .a(a_r[15:0]), .b(b_r[15:0]), .cin(cin_r),
    .s(s16_4), .cout(co16_4));
  carry_lookahead_adder #(.WIDTH(16), .SIZE(16)) u_16_16 (
    .clk(clk), .rst(rst), .a(a_r[15:0]), .b(b_r[15:0]), .cin(cin_r),
    .s(s16_16), .cout(co16_16));
  carry_lookahead_adder #(.WIDTH(8), .SIZE(1)) u_8_1 (
    .clk(clk), .rst(rst), .a(a_r[7:0]), .b(b_r[7:0]), .cin(cin_r),
    .s(s8_1), .cout(co8_1));
  carry_lookahead_adder #(.WIDTH(32), .SIZE(8)) u_32_8 (
    .clk(clk), .rst(rst), .a(a_r), .b(b_r), .cin(cin_r),
    .s(s32_8), .cout(co32_8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_16_4"},  {47'd0, co16_4, s16_4},   64'd0);
    check_val({tag, "_16_16"}, {47'd0, co16_16, s16_16}, 64'd0);
    check_val({tag, "_8_1"},   {55'd0, co8_1, s8_1},     64'd0);
    check_val({tag, "_32_8"},  {31'd0, co32_8, s32_8},   64'd0);
  endtask

  // Drive one operation, push its expected result, then compare one edge later.
  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       input string tag);
    exp_t e;
    exp_t got_e;
    a_r   = av;
    b_r   = bv;
    cin_r = cv;
    e.e16 = {1'b0, av[15:0]} + {1'b0, bv[15:0]} + {16'd0, cv};
    e.e8  = {1'b0, av[7:0]} + {1'b0, bv[7:0]} + {8'd0, cv};
    e.e32 = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      got_e = sb.pop_front();
      check_val({tag, "_16_4"},  {47'd0, co16_4, s16_4},   {47'd0, got_e.e16});
      check_val({tag, "_16_16"}, {47'd0, co16_16, s16_16}, {47'd0, got_e.e16});
      check_val({tag, "_8_1"},   {55'd0, co8_1, s8_1},     {55'd0, got_e.e8});
      check_val({tag, "_32_8"},  {31'd0, co32_8, s32_8},   {31'd0, got_e.e32});
    end
  endtask

  logic [31:0] corners [4];

  initial begin
    rst   = 1'b1;
    a_r   = 32'h0000_FFFF;
    b_r   = 32'h0000_0001;
    cin_r = 1'b1;
    #1;
    check_all_zero("rst_async_start");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end
    rst = 1'b0;
    drive(32'h0000_FFFF, 32'h0000_0001, 1'b1, "rst_release");
    check_val("rst_release_spec", {47'd0, co16_4, s16_4}, {47'd0, 1'b1, 16'h0001});

    drive(32'h0000_FFFF, 32'h0000_0000, 1'b1, "full_prop_c1");
    check_val("full_prop_c1_spec", {47'd0, co16_4, s16_4}, {47'd0, 1'b1, 16'h0000});
    drive(32'h0000_FFFF, 32'h0000_0000, 1'b0, "full_prop_c0");
    check_val("full_prop_c0_spec", {47'd0, co16_4, s16_4}, {47'd0, 1'b0, 16'hFFFF});

    drive(32'h0000_0F0F, 32'h0000_00F1, 1'b0, "gen_groups");
    check_val("gen_groups_spec", {47'd0, co16_4, s16_4}, {47'd0, 1'b0, 16'h1000});
    drive(32'h0000_8000, 32'h0000_8000, 1'b0, "msb_carry");
    check_val("msb_carry_spec", {47'd0, co16_4, s16_4}, {47'd0, 1'b1, 16'h0000});

    drive(32'h0000_1234, 32'h0000_4321, 1'b0, "b2b_first");
    check_val("b2b_first_spec", {47'd0, co16_4, s16_4}, {47'd0, 1'b0, 16'h5555});
    drive(32'h0000_FFFE, 32'h0000_0001, 1'b1, "b2b_second");
    check_val("b2b_second_spec", {47'd0, co16_4, s16_4}, {47'd0, 1'b1, 16'h0000});

    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h5555_5555;
    corners[3] = 32'hAAAA_AAAA;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int c = 0; c < 2; c++)
          drive(corners[i], corners[j], c[0], "corner");

    // Mid-stream async reset: outputs nonzero, then rst between edges.
    drive(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, "pre_async");
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async_mid");
    @(posedge clk);
    #1;
    check_all_zero("rst_async_hold");
    rst = 1'b0;
    drive(32'h89AB_CDEF, 32'h1111_1111, 1'b0, "post_async");

    for (int i = 0; i < 10000; i++)
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/carry_lookahead_adder.md
Name: carry_lookahead_adder

Overview:
- Parameterized two-level carry-lookahead adder with registered outputs.
- Computes {cout, s} = a + b + cin over WIDTH bits, using SIZE-bit lookahead groups and a second-level lookahead unit across groups.
- Datapath arithmetic primitive; the result register gives a fixed 1-cycle latency and clean timing boundaries for downstream logic.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be ≥1 and an integer multiple of SIZE; violation is an elaboration-time error.
- SIZE, 4, bits per lookahead group. Must be ≥1. Number of groups NG = WIDTH/SIZE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned/two's-complement agnostic.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- s  output  WIDTH  registered sum, s = (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of bit WIDTH-1.

Behaviour:
- Reset: rst high asynchronously forces s=0 and cout=0, independent of clk. Outputs hold 0 while rst is high. First capture occurs on the first rising clk edge after rst deasserts.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on s/cout after edge N. Throughput is one new operation every cycle; there is no handshake and no stall.
- Bit level: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Group level, per group k, bits k*SIZE .. k*SIZE+SIZE-1:
  - Internal carries are flattened lookahead from the group carry-in C[k]: c[j+1] = g[j] | p[j]&c[j], expanded into sum-of-products form (no ripple chain inside the group).
  - Group generate GG[k] and group propagate GP[k] = AND of p over the group.
- Second level:
  - C[0] = cin.
  - C[k+1] = GG[k] | GP[k]&C[k], expanded as lookahead over all groups.
  - cout = C[NG].
- Sum: s[i] = p[i] ^ c[i].
- Arithmetic: modular wrap-around. Overflow is indicated only by cout; there is no signed-overflow flag.
- Functional requirement: the registered result equals the behavioural expression a + b + cin (WIDTH+1 bits) for all inputs and all legal WIDTH/SIZE. SIZE = WIDTH (single group) and SIZE = 1 are legal.
- Purely combinational core: no state other than the output register. X on inputs may propagate; no X-masking is required.
- rst asserted mid-stream discards the in-flight result. After release, the next edge shows the result for the inputs present at that edge.

Test Plan:
- Reset: hold rst=1 with a=16'hFFFF, b=16'h0001, cin=1 and toggle clk → s=16'h0000, cout=0 on every cycle. Release rst → next edge gives s=16'h0001, cout=1.
- Full carry propagation: a=16'hFFFF, b=16'h0000, cin=1 → one cycle later s=16'h0000, cout=1. With cin=0 → s=16'hFFFF, cout=0.
- Generate across groups: a=16'h0F0F, b=16'h00F1, cin=0 → s=16'h1000, cout=0. Then a=16'h8000, b=16'h8000, cin=0 → s=16'h0000, cout=1.
- Back-to-back pipeline: present a=16'h1234,b=16'h4321,cin=0, then a=16'hFFFE,b=16'h0001,cin=1 on consecutive edges → outputs 16'h5555/0, then 16'h0000/1 on consecutive cycles, each exactly one cycle after its inputs.
- Parameter sweep: WIDTH/SIZE ∈ {16/4, 16/16, 8/1, 32/8}. Run ≥10,000 random a, b, cin per configuration and compare against the a+b+cin model one cycle delayed, plus corner values 0, all-ones and alternating patterns.
- Async reset mid-stream: assert rst between clock edges while outputs are nonzero → s and cout go to 0 immediately, without waiting for a clk edge.
